// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_bit_cyc(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter that must hold 0..bit_cyc-1.
  function automatic int calc_cnt_w(input int bit_cyc);
    return (bit_cyc <= 2) ? 1 : $clog2(bit_cyc);
  endfunction

endpackage

// File: rtl/uart_fifo_tx_sync_fifo.sv
// Single-clock FIFO with registered count; no fall-through, so a byte pushed
// into an empty FIFO becomes poppable one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: FIFO absorbs byte strobes, baud-timed FSM drains it.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       ovf_flag
);
  localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD_RATE);
  localparam int CW      = calc_cnt_w(BIT_CYC);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int CNTW    = $clog2(FIFO_DEPTH) + 1;

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_baud;
  logic [BW-1:0]   r_bit;
  logic [7:0]      r_shift;
  logic            r_ovf;
  logic [7:0]      w_dout;
  logic [CNTW-1:0] w_count;
  logic            w_full, w_empty, w_pop, w_push, w_bit_end, w_last_bit;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  assign w_push     = pi_flag & ~w_full;
  assign w_bit_end  = (r_baud == CW'(BIT_CYC - 1));
  assign w_last_bit = (r_bit == BW'(DATA_BITS - 1));
  assign fifo_full  = (w_count == CNTW'(FIFO_DEPTH));
  assign ovf_flag   = r_ovf;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (pi_data),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty) w_state_nxt = ST_START;
      ST_START:  if (w_bit_end) w_state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (w_bit_end && w_last_bit) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
`else
      ST_DATA:   if (w_bit_end && w_last_bit) w_state_nxt = ST_STOP;
`endif
      // Chain straight into the next start bit when more data is waiting.
      ST_STOP:   if (w_bit_end) w_state_nxt = w_empty ? ST_IDLE : ST_START;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx    = 1'b1;
    busy  = 1'b1;
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE:   begin busy = 1'b0; w_pop = ~w_empty; end
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = r_par;
`endif
      ST_STOP:   w_pop = w_bit_end & ~w_empty;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ovf   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (pi_flag && w_full) r_ovf <= 1'b1;
      if (r_state == ST_IDLE || w_bit_end) r_baud <= '0;
      else                                 r_baud <= r_baud + CW'(1);
      if (w_pop) begin
        r_shift <= w_dout;
        r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^w_dout;
`endif
      end else if (r_state == ST_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + BW'(1);
      end
    end
  end

endmodule
